// File: rtl/bfp_scale_ctrl_if.sv
// Clock and reset bundle shared by the FFT datapath blocks.
interface bfp_scale_ctrl_if;
   logic clock;
   logic reset;

   modport master (output clock, output reset);
   modport slave  (input clock, input reset);
endinterface

// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scaling controller: scans a frame through the shift-amount
// unit, picks one block shift, rewrites the frame in place and tracks the exponent.
module bfp_scale_ctrl #(
   parameter int width     = 8,
   parameter int shamtbits = 4,
   parameter int n_words   = 16,
   parameter int addr_bits = $clog2(n_words),
   parameter int exp_bits  = 6
) (
   bfp_scale_ctrl_if.slave             clk_rstn_i,
   input  logic                        start_i,
   input  logic                        exp_clr_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        mem_re_o,
   output logic [addr_bits-1:0]        mem_raddr_o,
   input  logic [width-1:0]            mem_rdata_i,
   output logic                        mem_we_o,
   output logic [addr_bits-1:0]        mem_waddr_o,
   output logic [width-1:0]            mem_wdata_o,
   output logic                        su_tvalid_o,
   output logic                        su_tlast_o,
   output logic [width-1:0]            su_data_o,
   output logic                        su_tready_o,
   input  logic                        su_tvalid_i,
   input  logic                        su_tlast_i,
   input  logic [width-1:0]            su_data_i,
   input  logic [shamtbits-1:0]        su_shamt_i,
   output logic [shamtbits-1:0]        shift_o,
   output logic signed [exp_bits-1:0]  blk_exp_o
);

   localparam int lbits = shamtbits - 1;
   localparam int cbits = addr_bits + 1;
   localparam int ebits = exp_bits + shamtbits;
   localparam logic [cbits-1:0] last_addr = cbits'(n_words - 1);
   localparam logic [cbits-1:0] full_cnt  = cbits'(n_words);
   localparam logic signed [ebits-1:0] exp_one = ebits'(1);
   localparam logic signed [ebits-1:0] exp_max = ebits'((1 << (exp_bits - 1)) - 1);
   localparam logic signed [ebits-1:0] exp_min = ebits'(-(1 << (exp_bits - 1)));

   generate
      if (!((width == 8 && shamtbits == 4) || (width == 16 && shamtbits == 5))) begin : g_bad_width
         $error("bfp_scale_ctrl: width/shamtbits must be 8/4 or 16/5");
      end
      if (n_words < 4 || (n_words & (n_words - 1)) != 0) begin : g_bad_len
         $error("bfp_scale_ctrl: n_words must be a power of two >= 4");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SCAN, COLLECT, SCALE, DONE} state_t;

   logic clock, reset;
   state_t state, state_next;
   logic [cbits-1:0] cnt;
   logic any_r, any_r_n, dec_right, beat, need_right, need_scale;
   logic [lbits-1:0] min_l, min_l_n, beat_l, dec_l;
   logic [width-1:0] shifted;
   logic [shamtbits-1:0] dec_code;
   logic signed [ebits-1:0] exp_wide, exp_sum, exp_sat;

   assign clock = clk_rstn_i.clock;
   assign reset = clk_rstn_i.reset;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Collection folds in the beat of the current cycle, so the tlast beat counts toward the decision.
   always_comb begin
      beat       = su_tvalid_i && (state == SCAN || state == COLLECT);
      beat_l     = su_shamt_i[lbits-1:0];
      any_r_n    = any_r | (beat & su_shamt_i[shamtbits-1]);
      min_l_n    = (beat && su_data_i != '0 && beat_l < min_l) ? beat_l : min_l;
      need_right = any_r_n;
      need_scale = any_r_n || (min_l_n != '1 && min_l_n != '0);
   end

   always_comb begin
      state_next  = state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      mem_re_o    = 1'b0;
      su_tready_o = 1'b0;
      case (state)
         IDLE: if (start_i) state_next = SCAN;
         SCAN: begin
            busy_o      = 1'b1;
            mem_re_o    = 1'b1;
            su_tready_o = 1'b1;
            if (cnt == last_addr) state_next = COLLECT;
         end
         COLLECT: begin
            busy_o      = 1'b1;
            su_tready_o = 1'b1;
            if (beat && su_tlast_i) state_next = need_scale ? SCALE : DONE;
         end
         SCALE: begin
            busy_o   = 1'b1;
            mem_re_o = (cnt < full_cnt);
            if (cnt == full_cnt) state_next = DONE;
         end
         DONE: begin
            busy_o     = 1'b1;
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_raddr_o = mem_re_o ? cnt[addr_bits-1:0] : '0;
      su_data_o   = su_tvalid_o ? mem_rdata_i : '0;
      if (dec_right) shifted = $signed(mem_rdata_i) >>> 1;
      else           shifted = mem_rdata_i << dec_l;
      mem_wdata_o = mem_we_o ? shifted : '0;
      dec_code    = dec_right ? {1'b1, {lbits{1'b0}}} : {1'b0, dec_l};
   end

   // Exponent arithmetic is done wide so the saturation compare cannot wrap.
   always_comb begin
      exp_wide = {{shamtbits{blk_exp_o[exp_bits-1]}}, blk_exp_o};
      if (dec_right) exp_sum = exp_wide + exp_one;
      else           exp_sum = exp_wide - $signed({{(ebits-lbits){1'b0}}, dec_l});
      if (exp_sum > exp_max)      exp_sat = exp_max;
      else if (exp_sum < exp_min) exp_sat = exp_min;
      else                        exp_sat = exp_sum;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         any_r       <= 1'b0;
         min_l       <= '1;
         dec_right   <= 1'b0;
         dec_l       <= '0;
         su_tvalid_o <= 1'b0;
         su_tlast_o  <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_waddr_o <= '0;
         shift_o     <= '0;
         blk_exp_o   <= '0;
      end else begin
         su_tvalid_o <= (state == SCAN);
         su_tlast_o  <= (state == SCAN) && (cnt == last_addr);
         mem_we_o    <= (state == SCALE) && mem_re_o;
         mem_waddr_o <= mem_raddr_o;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (exp_clr_i) blk_exp_o <= '0;
               if (start_i) begin
                  any_r <= 1'b0;
                  min_l <= '1;
               end
            end
            SCAN: begin
               cnt   <= (cnt == last_addr) ? '0 : cnt + 1'b1;
               any_r <= any_r_n;
               min_l <= min_l_n;
            end
            COLLECT: begin
               any_r <= any_r_n;
               min_l <= min_l_n;
               if (beat && su_tlast_i) begin
                  dec_right <= need_right;
                  dec_l     <= min_l_n;
                  if (!need_scale) shift_o <= '0;
               end
            end
            SCALE: begin
               cnt <= cnt + 1'b1;
               if (cnt == full_cnt) begin
                  shift_o   <= dec_code;
                  blk_exp_o <= exp_sat[exp_bits-1:0];
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bfp_scale_ctrl.sv
// Randomised self-checking bench for bfp_scale_ctrl with memory and shift-unit models.
module tb_bfp_scale_ctrl;
   localparam int width = 8, shamtbits = 4, n_words = 16, addr_bits = 4, exp_bits = 6;

   bfp_scale_ctrl_if clk_rstn ();
   logic start_i, exp_clr_i, busy_o, done_o, mem_re_o, mem_we_o;
   logic [addr_bits-1:0] mem_raddr_o, mem_waddr_o;
   logic [width-1:0] mem_rdata_i, mem_wdata_o, su_data_o, su_data_i;
   logic su_tvalid_o, su_tlast_o, su_tready_o, su_tvalid_i, su_tlast_i;
   logic [shamtbits-1:0] su_shamt_i, shift_o;
   logic signed [exp_bits-1:0] blk_exp_o;

   bfp_scale_ctrl #(.width(width), .shamtbits(shamtbits), .n_words(n_words),
                    .addr_bits(addr_bits), .exp_bits(exp_bits)) dut (
      .clk_rstn_i(clk_rstn), .start_i(start_i), .exp_clr_i(exp_clr_i),
      .busy_o(busy_o), .done_o(done_o), .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
      .mem_rdata_i(mem_rdata_i), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
      .mem_wdata_o(mem_wdata_o), .su_tvalid_o(su_tvalid_o), .su_tlast_o(su_tlast_o),
      .su_data_o(su_data_o), .su_tready_o(su_tready_o), .su_tvalid_i(su_tvalid_i),
      .su_tlast_i(su_tlast_i), .su_data_i(su_data_i), .su_shamt_i(su_shamt_i),
      .shift_o(shift_o), .blk_exp_o(blk_exp_o));

   initial clk_rstn.clock = 1'b0;
   always #5 clk_rstn.clock = ~clk_rstn.clock;

   // Frame memory with 1-cycle read latency, plus a bench-side load port.
   logic [width-1:0] mem [n_words];
   logic load_en;
   logic [addr_bits-1:0] load_addr;
   logic [width-1:0] load_data;
   always @(posedge clk_rstn.clock) begin
      if (mem_re_o) mem_rdata_i <= mem[mem_raddr_o];
      if (mem_we_o) mem[mem_waddr_o] <= mem_wdata_o;
      if (load_en) mem[load_addr] <= load_data;
   end

   // Shift-amount unit: r when the word has no guard bit, else l = redundant sign bits - 1.
   function automatic logic [3:0] unitCode(input logic [7:0] x);
      int red;
      bit run;
      red = 0;
      run = 1;
      for (int i = 6; i >= 0; i--) begin
         if (run && x[i] == x[7]) red++;
         else run = 0;
      end
      if (x[7] != x[6]) return 4'b1000;
      return {1'b0, 3'(red - 1)};
   endfunction

   always @(posedge clk_rstn.clock or posedge clk_rstn.reset) begin
      if (clk_rstn.reset) begin
         su_tvalid_i <= 1'b0;
         su_tlast_i  <= 1'b0;
         su_data_i   <= '0;
         su_shamt_i  <= '0;
      end else begin
         su_tvalid_i <= su_tvalid_o;
         su_tlast_i  <= su_tlast_o & su_tvalid_o;
         su_data_i   <= su_data_o;
         su_shamt_i  <= unitCode(su_data_o);
      end
   end

   int we_count = 0, done_count = 0;
   always @(negedge clk_rstn.clock) begin
      if (mem_we_o) we_count <= we_count + 1;
      if (done_o) done_count <= done_count + 1;
   end

   int errors = 0, checks = 0;
   int model_exp = 0;
   int frame [n_words];
   int expect_word [n_words];

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic loadFrame();
      for (int i = 0; i < n_words; i++) begin
         @(negedge clk_rstn.clock);
         load_en   = 1'b1;
         load_addr = addr_bits'(i);
         load_data = width'(frame[i]);
      end
      @(negedge clk_rstn.clock);
      load_en = 1'b0;
   endtask

   // Reference: block shift chosen from word magnitudes with plain integer arithmetic.
   task automatic applyStimulus(input int abort_at, input bit extra_starts, input bit clr_with_start);
      bit big;
      int minl, k, cyc, done_at, first_we, base_we, base_done, exp_shift, new_exp;
      bit scale;
      big = 0;
      minl = 99;
      for (int i = 0; i < n_words; i++) begin
         if (frame[i] > 63 || frame[i] < -64) big = 1;
         else if (frame[i] != 0) begin
            k = 0;
            while (k < 6 && frame[i] * (2 << k) <= 63 && frame[i] * (2 << k) >= -64) k++;
            if (k < minl) minl = k;
         end
      end
      if (clr_with_start) model_exp = 0;
      scale = big || (minl != 99 && minl != 0);
      new_exp = model_exp;
      exp_shift = 0;
      for (int i = 0; i < n_words; i++) expect_word[i] = frame[i];
      if (big) begin
         exp_shift = 8;
         new_exp = (model_exp + 1 > 31) ? 31 : model_exp + 1;
         for (int i = 0; i < n_words; i++)
            expect_word[i] = (frame[i] < 0 && frame[i] % 2 != 0) ? frame[i] / 2 - 1 : frame[i] / 2;
      end else if (scale) begin
         exp_shift = minl;
         new_exp = (model_exp - minl < -32) ? -32 : model_exp - minl;
         for (int i = 0; i < n_words; i++) expect_word[i] = frame[i] * (1 << minl);
      end

      loadFrame();
      base_we = we_count;
      base_done = done_count;
      @(negedge clk_rstn.clock);
      start_i = 1'b1;
      exp_clr_i = clr_with_start;
      @(negedge clk_rstn.clock);
      start_i = 1'b0;
      exp_clr_i = 1'b0;
      cyc = 1;
      done_at = 0;
      first_we = 0;
      while (cyc < 100 && done_at == 0) begin
         if (cyc == 1) checkOutput("tready_c1", int'(su_tready_o), 1);
         if (cyc == 2) checkOutput("tvalid_c2", int'(su_tvalid_o), 1);
         if (cyc == n_words + 1) checkOutput("tlast", int'(su_tlast_o), 1);
         if (mem_we_o && first_we == 0) first_we = cyc;
         if (done_o) done_at = cyc;
         if (cyc == abort_at) begin
            clk_rstn.reset = 1'b1;
            @(negedge clk_rstn.clock);
            checkOutput("rst_busy", int'(busy_o), 0);
            checkOutput("rst_re_we", int'({mem_re_o, mem_we_o, done_o}), 0);
            checkOutput("rst_su", int'({su_tvalid_o, su_tlast_o, su_tready_o}), 0);
            checkOutput("rst_shift", int'(shift_o), 0);
            checkOutput("rst_exp", int'(blk_exp_o), 0);
            clk_rstn.reset = 1'b0;
            model_exp = 0;
            return;
         end
         if (extra_starts && (cyc == 5 || cyc == n_words + 6)) start_i = 1'b1;
         else start_i = 1'b0;
         if (done_at == 0) begin
            @(negedge clk_rstn.clock);
            cyc++;
         end
      end
      start_i = 1'b0;
      checkOutput("done_cycle", done_at, scale ? 2 * n_words + 4 : n_words + 3);
      checkOutput("first_we", first_we, scale ? n_words + 4 : 0);
      @(negedge clk_rstn.clock);
      checkOutput("busy_after", int'(busy_o), 0);
      checkOutput("shift", int'(shift_o), exp_shift);
      checkOutput("blk_exp", int'(blk_exp_o), new_exp);
      if (extra_starts) repeat (30) @(negedge clk_rstn.clock);
      checkOutput("we_count", we_count - base_we, scale ? n_words : 0);
      checkOutput("done_count", done_count - base_done, 1);
      for (int i = 0; i < n_words; i++)
         checkOutput($sformatf("word%0d", i), int'($signed(mem[i])), expect_word[i]);
      model_exp = new_exp;
   endtask

   task automatic fillFrame(input int v);
      for (int i = 0; i < n_words; i++) frame[i] = v;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int amp, kind;
      clk_rstn.reset = 1'b1;
      start_i = 1'b0;
      exp_clr_i = 1'b0;
      load_en = 1'b0;
      load_addr = '0;
      load_data = '0;
      repeat (3) @(negedge clk_rstn.clock);
      checkOutput("reset_busy", int'(busy_o), 0);
      checkOutput("reset_outs", int'({done_o, mem_re_o, mem_we_o, su_tready_o, su_tvalid_o}), 0);
      checkOutput("reset_shift", int'(shift_o), 0);
      checkOutput("reset_exp", int'(blk_exp_o), 0);
      clk_rstn.reset = 1'b0;

      fillFrame(1); frame[0] = 3; frame[1] = -2;
      applyStimulus(0, 0, 0);
      fillFrame(1); frame[3] = 100; frame[7] = -7;
      applyStimulus(0, 0, 1);
      fillFrame(0);
      applyStimulus(0, 0, 0);

      fillFrame(0); frame[5] = 1;
      applyStimulus(0, 0, 1);
      for (int p = 0; p < 5; p++) begin
         fillFrame(0); frame[p] = -1; frame[p + 1] = 1;
         applyStimulus(0, 0, 0);
      end
      fillFrame(0); frame[9] = 3;
      applyStimulus(0, 0, 0);
      @(negedge clk_rstn.clock);
      exp_clr_i = 1'b1;
      @(negedge clk_rstn.clock);
      exp_clr_i = 1'b0;
      model_exp = 0;
      checkOutput("exp_clear", int'(blk_exp_o), 0);

      for (int p = 0; p < 33; p++) begin
         fillFrame(0); frame[p % n_words] = 100;
         applyStimulus(0, 0, 0);
      end

      fillFrame(2); frame[4] = -3;
      applyStimulus(0, 1, 0);
      fillFrame(1); frame[2] = 5;
      applyStimulus(25, 0, 0);
      fillFrame(1); frame[2] = 5;
      applyStimulus(0, 0, 0);

      for (int r = 0; r < 12; r++) begin
         kind = int'($urandom_range(0, 3));
         amp = 1 << $urandom_range(0, 6);
         for (int i = 0; i < n_words; i++) begin
            case (kind)
               0: frame[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * amp)) - amp : 0;
               1: frame[i] = int'($urandom_range(0, 2 * amp)) - amp;
               2: frame[i] = int'($signed(8'($urandom)));
               default: frame[i] = int'($urandom_range(0, 6)) - 3;
            endcase
            if (frame[i] > 127) frame[i] = 127;
            if (frame[i] < -128) frame[i] = -128;
         end
         applyStimulus(0, 0, (r % 5) == 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
